data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DMA_BURST, default 4: maximum consecutive DMA grants while cpu_req is high.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: number of consecutive denied DMA-request cycles that forces a DMA grant.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports cpu_req (in, 1), cpu_we (in, 3), cpu_addr (in, 32), cpu_wdata (in, 32): CPU load/store request; cpu_we 0 means read, nonzero is the store-size code.
REQ-006 SHALL have ports cpu_gnt (out, 1), cpu_rvalid (out, 1), cpu_rdata (out, 32): CPU grant and read response.
REQ-007 SHALL have ports dma_req (in, 1), dma_we (in, 3), dma_addr (in, 32), dma_wdata (in, 32), dma_gnt (out, 1), dma_rvalid (out, 1), dma_rdata (out, 32): DMA port, with the same semantics as the CPU port.
REQ-008 SHALL have ports mem_we (out, 3), mem_addr (out, 32), mem_wd (out, 32): drive to the data memory WE, A and WD inputs.
REQ-009 SHALL have port mem_rd (in, 32): combinational read data from the data memory.
REQ-010 SHALL have port stall (out, 1): CPU request pending but not granted this cycle.

Function
REQ-011 SHALL issue at most one grant per cycle; cpu_gnt and dma_gnt are combinational from the requests, state and counters.
REQ-012 SHALL hold FSM states IDLE, CPU, DMA, recording the owner of the last grant; the next state is the granted port, or IDLE if no port is granted.
REQ-013 SHALL arbitrate in this priority order:
- (a) DMA if state==DMA, dma_req, and burst_cnt<MAX_DMA_BURST;
- (b) DMA if dma_req and starve_cnt==STARVE_LIMIT;
- (c) CPU if cpu_req;
- (d) DMA if dma_req;
- (e) otherwise no grant.
REQ-014 SHALL, in a granted cycle, pass the granted port's we/addr/wdata to mem_we/mem_addr/mem_wd unchanged.
REQ-015 SHALL drive mem_we=0, mem_addr=0 and mem_wd=0 in an ungranted cycle, so no spurious write occurs.
REQ-016 SHALL commit a granted write at the same rising edge; writes produce no rvalid.
REQ-017 SHALL, for a granted read (we==0), register mem_rd into the port's rdata at the edge and assert that port's rvalid for exactly the following cycle.
- Read latency is 1 cycle from grant.
REQ-018 SHALL hold rdata until the next read response on that port, with rvalid low in between.
REQ-019 SHALL update burst_cnt (width clog2(MAX_DMA_BURST)+1):
- +1 on each DMA grant while cpu_req is high, saturating at MAX_DMA_BURST;
- cleared on any CPU grant or any cycle with dma_req low.
REQ-020 SHALL update starve_cnt (width clog2(STARVE_LIMIT)+1):
- +1 each cycle dma_req && !dma_gnt, saturating at STARVE_LIMIT;
- cleared on dma_gnt or dma_req low.
REQ-021 SHALL grant DMA back-to-back indefinitely while cpu_req is low, regardless of burst_cnt.
REQ-022 SHALL assert stall = cpu_req && !cpu_gnt.
REQ-023 SHALL resolve simultaneous CPU and DMA requests from IDLE or CPU state to CPU, unless rule (b) applies.
REQ-024 SHALL allow a requester to change addr/we every cycle; each grant is an independent single-beat transfer.
REQ-025 SHALL require no handshake beyond req/gnt: a requester keeps req high until it sees gnt.

Reset
REQ-026 SHALL, on rst low, immediately set state=IDLE, burst_cnt=0, starve_cnt=0, cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0.
REQ-027 SHALL force cpu_gnt=0, dma_gnt=0, stall=0 and mem_we=0 combinationally while rst is low, including mid-transfer.
- A read granted in the cycle reset asserts produces no rvalid.
REQ-028 SHALL begin arbitration on the first rising edge after rst deasserts.

Verification
REQ-029 SHALL cover CPU read only: cpu_req=1, cpu_we=0, addr=0x10, mem_rd=0xDEADBEEF -> cpu_gnt same cycle, next cycle cpu_rvalid=1 with cpu_rdata=0xDEADBEEF; stall=0.
REQ-030 SHALL cover simultaneous requests from IDLE: cpu_req=dma_req=1 -> cpu_gnt=1, dma_gnt=0, starve_cnt increments; DMA granted the first cycle cpu_req drops.
REQ-031 SHALL cover burst cap: DMA already owner, cpu_req asserted with dma_req held -> exactly 4 further DMA grants with stall=1, then cpu_gnt=1 on the 5th cycle.
REQ-032 SHALL cover starvation: cpu_req and dma_req held high continuously from IDLE -> CPU granted cycles 0-7, DMA granted at cycle 8 (starve_cnt==8), then DMA continues under rule (a) up to the burst cap.
REQ-033 SHALL cover DMA write: dma_we=3'b010, addr=0x20, wdata=0x1234 with no CPU request -> mem_we=3'b010, mem_addr=0x20, mem_wd=0x1234 that cycle, and dma_rvalid stays 0.
REQ-034 SHALL cover reset mid-read: rst driven low in the cycle of a granted CPU read -> gnt drops immediately, cpu_rvalid=0 next cycle, all counters 0; normal grants resume after rst returns high.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory.
// CPU normally wins; DMA bursts are capped and a starved DMA request is forced through.
module data_mem_arbiter #(
    parameter int MAX_DMA_BURST = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [2:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [2:0]  dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [2:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        stall
);

    localparam int BW = $clog2(MAX_DMA_BURST) + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_DMA_BURST);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_next;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_next;
    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          r_cpu_rvalid;
    logic          r_dma_rvalid;
    logic [31:0]   r_cpu_rdata;
    logic [31:0]   r_dma_rdata;

    // Grants are gated by reset so nothing reaches memory while rst is low.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (rst) begin
            if (dma_req && (r_state == DMA) && (r_burst_cnt < BURST_MAX)) begin
                w_dma_gnt = 1'b1;
            end else if (dma_req && (r_starve_cnt == STARVE_MAX)) begin
                w_dma_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (dma_req) begin
                w_dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = IDLE;
        if (w_cpu_gnt) begin
            w_state_next = CPU;
        end else if (w_dma_gnt) begin
            w_state_next = DMA;
        end

        w_burst_next = r_burst_cnt;
        if (w_cpu_gnt || !dma_req) begin
            w_burst_next = '0;
        end else if (w_dma_gnt && cpu_req && (r_burst_cnt < BURST_MAX)) begin
            w_burst_next = r_burst_cnt + BW'(1);
        end

        w_starve_next = r_starve_cnt;
        if (!dma_req || w_dma_gnt) begin
            w_starve_next = '0;
        end else if (r_starve_cnt < STARVE_MAX) begin
            w_starve_next = r_starve_cnt + SW'(1);
        end
    end

    always_comb begin
        mem_we   = 3'd0;
        mem_addr = 32'd0;
        mem_wd   = 32'd0;
        if (w_cpu_gnt) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wdata;
        end else if (w_dma_gnt) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_wd   = dma_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_burst_cnt  <= '0;
            r_starve_cnt <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= 32'd0;
            r_dma_rdata  <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_burst_cnt  <= w_burst_next;
            r_starve_cnt <= w_starve_next;
            r_cpu_rvalid <= w_cpu_gnt && (cpu_we == 3'd0);
            r_dma_rvalid <= w_dma_gnt && (dma_we == 3'd0);
            // Read data is held until the next read response on that port.
            if (w_cpu_gnt && (cpu_we == 3'd0)) begin
                r_cpu_rdata <= mem_rd;
            end
            if (w_dma_gnt && (dma_we == 3'd0)) begin
                r_dma_rdata <= mem_rd;
            end
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign stall      = cpu_req && !w_cpu_gnt && rst;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rdata  = r_dma_rdata;

endmodule
